// File: rtl/clk_divider_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_divider_pkg;

  // Smallest divide ratio the counter can honour; 0 and 1 are clamped up to this.
  localparam int unsigned MIN_RATIO = 2;

  // Divider control state: IDLE holds clk_out low, RUN produces periods.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : clk_divider_pkg

// File: rtl/clk_divider.sv
// Programmable integer clock divider.
// Produces clk_out with a period of R clk cycles, high for ceil(R/2) cycles.
// Ratio changes requested while running are deferred to the next wrap point so
// that no period is ever truncated or stretched; en falling also only takes
// effect at a wrap point, so clk_out never shows a runt pulse.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_RATIO = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic             load,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  // Ratios below MIN_RATIO cannot form a high and a low phase.
  function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] r);
    return (r < WIDTH'(MIN_RATIO)) ? WIDTH'(MIN_RATIO) : r;
  endfunction

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] ratio_q,    ratio_d;
  logic [WIDTH-1:0] pend_q,     pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             ack_q,      ack_d;
  logic             busy_q,     busy_d;

  logic             wrap;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] high_len;

  // Next-state logic: counter, ratio hand-over and the registered outputs.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;

    wrap     = (cnt_q == ratio_q - WIDTH'(1));
    load_val = clamp_ratio(div_ratio);

    case (state_q)
      IDLE: begin
        // Nothing is in flight, so a new ratio can take effect immediately.
        if (load) begin
          ratio_d = load_val;
          ack_d   = 1'b1;
        end
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (!en) state_d = IDLE;
          // A load in the wrap cycle is newer than any pending value.
          if (load) begin
            ratio_d    = load_val;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            ratio_d    = pend_q;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          // Hold the request until the period ends; later loads overwrite it.
          if (load) begin
            pend_d     = load_val;
            pend_vld_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // ceil(R/2) without the overflow that (R+1)>>1 would hit at R = 2^WIDTH-1.
    high_len  = (ratio_d >> 1) + {{(WIDTH-1){1'b0}}, ratio_d[0]};
    busy_d    = (state_d == RUN);
    clk_out_d = busy_d && (cnt_d < high_len);
    tick_d    = busy_d && (cnt_d == ratio_d - WIDTH'(1));
  end

  // State and output registers; outputs come straight from flops so clk_out is glitch-free.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ratio_q    <= WIDTH'(RESET_RATIO);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign busy     = busy_q;
  assign load_ack = ack_q;

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider.
// Stimulus pushes the hand-computed output vector {clk_out,tick,busy,load_ack}
// expected after each clock edge into a queue; a monitor on the falling edge
// pops and compares it against the DUT.
module tb_clk_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [WIDTH-1:0] div_ratio;
  logic             load;
  logic             load_ack;
  logic             clk_out;
  logic             tick;
  logic             busy;

  clk_divider #(.WIDTH(WIDTH), .RESET_RATIO(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .div_ratio (div_ratio),
    .load      (load),
    .load_ack  (load_ack),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to tag expectations with the edge they belong to.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation whose edge has been reached.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      check(exp_q[0].tag, {28'd0, clk_out, tick, busy, load_ack}, {28'd0, exp_q[0].v});
      void'(exp_q.pop_front());
    end
  end

  function automatic logic bit_at(input string s, input int i);
    return (s[i] == "1");
  endfunction

  // Drive one input vector per edge; each column string holds one char per edge.
  task automatic run(input string tag, input logic [WIDTH-1:0] ratio,
                     input string en_s, input string ld_s,
                     input string co_s, input string tk_s,
                     input string bz_s, input string ak_s);
    exp_t e;
    for (int i = 0; i < en_s.len(); i++) begin
      en        = bit_at(en_s, i);
      load      = bit_at(ld_s, i);
      div_ratio = ratio;
      e.cyc = cyc + 1;
      e.v   = {bit_at(co_s, i), bit_at(tk_s, i), bit_at(bz_s, i), bit_at(ak_s, i)};
      e.tag = $sformatf("%s[%0d]", tag, i);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    load = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    en        = 1'b0;
    load      = 1'b0;
    div_ratio = '0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, clk_out, tick, busy, load_ack}, 32'd0);
    reset_n = 1'b1;

    //    tag          ratio en             load           clk_out        tick           busy           load_ack
    run("idle_hold",   8'd0, "00",          "00",          "00",          "00",          "00",          "00");
    run("default_r2",  8'd0, "11111100",    "00000000",    "10101000",    "01010100",    "11111100",    "00000000");
    run("idle_load5",  8'd5, "01111111111", "10000000000", "01110011100", "00000100001", "01111111111", "10000000000");
    run("wrap_ld_off", 8'd4, "00",          "10",          "00",          "00",          "00",          "10");
    run("r4_to_r6",    8'd6, "11111111111", "00100000000", "11001110001", "00010000010", "11111111111", "00001000000");
    run("load0",       8'd0, "1",           "1",           "1",           "0",           "1",           "0");
    run("load1",       8'd1, "1111111",     "0100000",     "1000101",     "0001010",     "1111111",     "0000100");
    run("load8",       8'd8, "11",          "10",          "01",          "10",          "11",          "01");
    run("r8_en_drop",  8'd0, "110000000",   "000000000",   "111000000",   "000000100",   "111111100",   "000000000");
    run("en_reassert", 8'd0, "1000011111",  "0000000000",  "1111000011",  "0000000100",  "1111111111",  "0000000000");
    run("r8_run",      8'd0, "111111",      "000000",      "110000",      "000001",      "111111",      "000000");
    run("wrap_load3",  8'd3, "1111",        "1000",        "1101",        "0010",        "1111",        "1000");
    run("load10",      8'd10, "111",        "100",         "101",         "010",         "111",         "001");
    run("r10_cnt3",    8'd0, "111",         "000",         "111",         "000",         "111",         "000");

    // Asynchronous reset in the middle of a high phase (cnt=3 of R=10).
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async", {28'd0, clk_out, tick, busy, load_ack}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", {28'd0, clk_out, tick, busy, load_ack}, 32'd0);
    en = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run("after_reset", 8'd0, "001111",     "000000",      "001010",      "000101",      "001111",      "000000");

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_clk_divider

// File: doc/clk_divider.md
CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the divide ratio and the internal counter.
REQ-002 Parameter: RESET_RATIO, default 2, divide ratio held after reset; legal range 2..2^WIDTH-1.
REQ-003 Port: clk  input  1  master clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous digital reset, active-low.
REQ-005 Port: en  input  1  run request; high = generate divided clock.
REQ-006 Port: div_ratio  input  WIDTH  requested divide ratio N; sampled only when load=1.
REQ-007 Port: load  input  1  single-cycle request to adopt div_ratio.
REQ-008 Port: load_ack  output  1  one-cycle pulse on the cycle the new ratio takes effect.
REQ-009 Port: clk_out  output  1  divided clock, driven directly from a flop, glitch-free.
REQ-010 Port: tick  output  1  one-cycle pulse in the last clk cycle of each clk_out period.
REQ-011 Port: busy  output  1  high while a clk_out period is in progress.

Function
REQ-012 The active ratio register R shall hold the divide ratio in use; ratios 0 and 1 written via load shall be clamped to 2.
REQ-013 The counter cnt shall run 0..R-1 and wrap to 0 while running; clk_out period = R clk cycles.
REQ-014 clk_out shall be high for H = ceil(R/2) cycles (cnt < H) and low for R-H cycles; even R gives 50% duty, odd R gives one extra high cycle.
REQ-015 Latency: en sampled high at edge t while idle -> cnt=0, clk_out=1, busy=1 after edge t.
REQ-016 tick shall be 1 exactly in the cycle where cnt == R-1 and busy=1, registered.
REQ-017 States: IDLE (busy=0, clk_out=0, cnt=0) and RUN; IDLE->RUN on en=1; RUN->IDLE only at the wrap point (cnt == R-1) with en=0.
REQ-018 en deasserted mid-period shall not truncate the period; the period completes, clk_out ends low, no runt pulse.
REQ-019 en re-asserted before the wrap point shall continue without any gap.
REQ-020 load in IDLE shall update R on the next edge with load_ack=1 that cycle.
REQ-021 load in RUN shall store div_ratio in a pending register; R updates at the next wrap point, load_ack pulses in the first cycle of the new period.
REQ-022 Multiple loads before a wrap point: last value wins, exactly one load_ack.
REQ-023 load and en fall at the same wrap point: R updates, block enters IDLE, load_ack still pulses.
REQ-024 load coinciding with the wrap-point cycle shall apply at that wrap (new period uses new R).

Reset
REQ-025 Asynchronous assertion of reset_n=0 shall force clk_out=0, tick=0, busy=0, load_ack=0, cnt=0, pending cleared, R=RESET_RATIO.
REQ-026 Reset mid-period shall abort immediately; after release, the block stays IDLE until en is sampled high.

Structure
REQ-027 Package clk_divider_pkg shall hold MIN_RATIO=2 and the IDLE/RUN state enum type.
REQ-028 The block shall be a single module with no sub-modules; clk_out shall not pass through combinational logic after its flop.

Verification
REQ-029 Reset, en=1, default R=2 -> clk_out toggles every cycle, tick every 2nd cycle, busy=1.
REQ-030 load div_ratio=5 in IDLE, then en=1 -> clk_out 3 cycles high, 2 low, period 5; load_ack one cycle.
REQ-031 R=4 running, load div_ratio=6 at cnt=1 -> current period completes in 4 cycles, next period 6 cycles (3H/3L), load_ack in its first cycle.
REQ-032 R=8, en dropped at cnt=2 -> clk_out high for cycles 0-3, low 4-7, then busy=0, clk_out stays 0.
REQ-033 load div_ratio=0, then load div_ratio=1 before wrap -> single load_ack, R=2.
REQ-034 reset_n pulsed low at cnt=3 of R=10 -> all outputs 0 immediately; after release with en=1, period restarts at R=2.
